// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, types and schedule sigma functions for the round controller.
package sha256_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0]       word_t;
    typedef logic [0:7][WORD_W-1:0]  hash_t;
    typedef logic [0:63][WORD_W-1:0] k_table_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        ADD,
        OUT
    } state_t;

    localparam hash_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam k_table_t K_TABLE = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(word_t x, int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t sig0(word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sig1(word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// Rolling 16-word SHA-256 message schedule; w_o is always the current round word W_t.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [511:0] blk_i,
    output word_t        w_o
);

    word_t w_q [16];
    word_t w_new;

    // Newest word computed from the window W[t-16..t-1] held in w_q[0..15].
    assign w_new = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];
    assign w_o   = w_q[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else if (load_i) begin
            for (int i = 0; i < 16; i++) w_q[i] <= blk_i[511-32*i -: 32];
        end else if (shift_i) begin
            for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
            w_q[15] <= w_new;
        end
    end

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 block sequencer driving an external round core; optional chaining via SHA256_MULTI_BLOCK_EN.
//
// state | meaning
// IDLE  | waiting for a message block, blk_ready_o high
// LOAD  | push current H into the round core
// ROUND | 64 core_en_o pulses, one every ROUND_LAT cycles
// ADD   | fold core state into H
// OUT   | present digest until digest_ready_i
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int ROUND_LAT = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         blk_valid_i,
    output logic         blk_ready_o,
    input  logic [511:0] blk_data_i,
    input  logic         blk_last_i,
    output logic         core_load_o,
    output hash_t        core_init_o,
    output logic         core_en_o,
    output word_t        core_w_o,
    output word_t        core_k_o,
    input  hash_t        core_state_i,
    output logic         digest_valid_o,
    input  logic         digest_ready_i,
    output logic [255:0] digest_o
);

    localparam logic [1:0] LAT_RELOAD = 2'(ROUND_LAT - 1);
    localparam logic [6:0] ROUNDS     = 7'd64;

    state_t     state_q, state_d;
    logic [6:0] t_q, t_d;
    logic [1:0] lat_q, lat_d;
    hash_t      h_q, h_d;
    logic       blk_final;
    logic       sched_load;
    word_t      sched_w;

`ifdef SHA256_MULTI_BLOCK_EN
    logic last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                              last_q <= 1'b0;
        else if (state_q == IDLE && blk_valid_i)  last_q <= blk_last_i;
    end

    assign blk_final = last_q;
`else
    logic unused_last;

    assign unused_last = blk_last_i;
    assign blk_final   = 1'b1;
`endif

    sha256_msg_sched u_sched (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (sched_load),
        .shift_i (core_en_o),
        .blk_i   (blk_data_i),
        .w_o     (sched_w)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            t_q     <= '0;
            lat_q   <= '0;
            h_q     <= IV;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            lat_q   <= lat_d;
            h_q     <= h_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        t_d            = t_q;
        lat_d          = lat_q;
        h_d            = h_q;
        sched_load     = 1'b0;
        blk_ready_o    = 1'b0;
        core_load_o    = 1'b0;
        core_init_o    = '0;
        core_en_o      = 1'b0;
        core_w_o       = '0;
        core_k_o       = '0;
        digest_valid_o = 1'b0;
        digest_o       = '0;

        unique case (state_q)
            IDLE: begin
                blk_ready_o = rst_ni;
                if (blk_valid_i) begin
                    sched_load = 1'b1;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                core_load_o = 1'b1;
                core_init_o = h_q;
                t_d         = '0;
                lat_d       = '0;
                state_d     = ROUND;
            end
            ROUND: begin
                if (lat_q == '0) begin
                    core_en_o = 1'b1;
                    core_w_o  = sched_w;
                    core_k_o  = K_TABLE[t_q[5:0]];
                    t_d       = t_q + 7'd1;
                    lat_d     = LAT_RELOAD;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
                // Leave once the core has had its full latency after the last pulse.
                if (lat_d == '0 && t_d == ROUNDS) state_d = ADD;
            end
            ADD: begin
                for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + core_state_i[i];
                state_d = blk_final ? OUT : IDLE;
            end
            OUT: begin
                digest_valid_o = 1'b1;
                digest_o       = h_q;
                if (digest_ready_i) begin
                    h_d     = IV;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench: two controllers (ROUND_LAT 1 and 3) each paired with a round core, checked against a block-level SHA-256 model.
module tb_sha256_round_ctrl;

    typedef logic [0:7][31:0]  hash_t;
    typedef logic [0:63][31:0] sched_t;

    localparam hash_t IV_M = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam sched_t KT = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h0}}};
    localparam logic [511:0] BLK_TWO_A = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] BLK_TWO_B = {{15{32'h0}}, 32'h000001c0};

    localparam logic [255:0] DIG_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] DIG_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         blk_valid    [2];
    logic         blk_ready    [2];
    logic [511:0] blk_data     [2];
    logic         blk_last     [2];
    logic         core_load    [2];
    hash_t        core_init    [2];
    logic         core_en      [2];
    logic [31:0]  core_w       [2];
    logic [31:0]  core_k       [2];
    hash_t        core_state   [2];
    logic         digest_valid [2];
    logic         digest_ready [2];
    logic [255:0] digest       [2];

    int checks = 0;
    int errors = 0;

    // Block-level model state per instance: cycles since accept (-1 when not in a block).
    int     cyc     [2];
    logic   outq    [2];
    logic   fin_m   [2];
    hash_t  mh      [2];
    hash_t  mh_next [2];
    sched_t mw      [2];

    always #5 clk = ~clk;

    sha256_round_ctrl #(.ROUND_LAT(1)) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .blk_valid_i(blk_valid[0]), .blk_ready_o(blk_ready[0]), .blk_data_i(blk_data[0]), .blk_last_i(blk_last[0]),
        .core_load_o(core_load[0]), .core_init_o(core_init[0]), .core_en_o(core_en[0]),
        .core_w_o(core_w[0]), .core_k_o(core_k[0]), .core_state_i(core_state[0]),
        .digest_valid_o(digest_valid[0]), .digest_ready_i(digest_ready[0]), .digest_o(digest[0])
    );

    sha256_round_ctrl #(.ROUND_LAT(3)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .blk_valid_i(blk_valid[1]), .blk_ready_o(blk_ready[1]), .blk_data_i(blk_data[1]), .blk_last_i(blk_last[1]),
        .core_load_o(core_load[1]), .core_init_o(core_init[1]), .core_en_o(core_en[1]),
        .core_w_o(core_w[1]), .core_k_o(core_k[1]), .core_state_i(core_state[1]),
        .digest_valid_o(digest_valid[1]), .digest_ready_i(digest_ready[1]), .digest_o(digest[1])
    );

    function automatic int lat_of(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] rotr(logic [31:0] x, int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic sched_t expand(logic [511:0] b);
        sched_t w;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = b[511-32*t -: 32];
            else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                      + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        end
        return w;
    endfunction

    function automatic hash_t rnd(hash_t s, logic [31:0] w, logic [31:0] k);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic hash_t compress(hash_t h, logic [511:0] blk);
        sched_t w;
        hash_t  s, r;
        w = expand(blk);
        s = h;
        for (int t = 0; t < 64; t++) s = rnd(s, w[t], KT[t]);
        for (int i = 0; i < 8; i++) r[i] = h[i] + s[i];
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[511-32*k -: 32] = $urandom();
        return r;
    endfunction

    function automatic string nm(int i, string s);
        return $sformatf("u%0d_%s", i, s);
    endfunction

    // Round core stand-in: one compression round per enable, load replaces state.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) core_state[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (core_load[i])    core_state[i] <= core_init[i];
                else if (core_en[i]) core_state[i] <= rnd(core_state[i], core_w[i], core_k[i]);
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                cyc[i]  <= -1;
                outq[i] <= 1'b0;
                fin_m[i] <= 1'b0;
                mh[i]   <= IV_M;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (outq[i]) begin
                    if (digest_ready[i]) begin
                        outq[i] <= 1'b0;
                        mh[i]   <= IV_M;
                    end
                end else if (cyc[i] < 0) begin
                    if (blk_valid[i]) begin
                        mw[i]      <= expand(blk_data[i]);
                        mh_next[i] <= compress(mh[i], blk_data[i]);
`ifdef SHA256_MULTI_BLOCK_EN
                        fin_m[i]   <= blk_last[i];
`else
                        fin_m[i]   <= 1'b1;
`endif
                        cyc[i]     <= 1;
                    end
                end else if (cyc[i] == 2 + 64 * lat_of(i)) begin
                    mh[i]   <= mh_next[i];
                    outq[i] <= fin_m[i];
                    cyc[i]  <= -1;
                end else begin
                    cyc[i] <= cyc[i] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            int          lat, c, j;
            logic        e_en, e_load, e_ready;
            logic [31:0] e_w, e_k;
            lat     = lat_of(i);
            c       = cyc[i];
            e_load  = (c == 1);
            e_en    = (c >= 2) && (c < 2 + 64 * lat) && ((c - 2) % lat == 0);
            j       = e_en ? (c - 2) / lat : 0;
            e_w     = e_en ? mw[i][j] : 32'h0;
            e_k     = e_en ? KT[j] : 32'h0;
            e_ready = rst_n && (c < 0) && !outq[i];
            chk(nm(i, "blk_ready"),    256'(blk_ready[i]),    256'(e_ready));
            chk(nm(i, "core_load"),    256'(core_load[i]),    256'(e_load));
            chk(nm(i, "core_init"),    core_init[i],          e_load ? mh[i] : '0);
            chk(nm(i, "core_en"),      256'(core_en[i]),      256'(e_en));
            chk(nm(i, "core_w"),       256'(core_w[i]),       256'(e_w));
            chk(nm(i, "core_k"),       256'(core_k[i]),       256'(e_k));
            chk(nm(i, "en_and_load"),  256'(core_en[i] & core_load[i]), 256'(0));
            chk(nm(i, "digest_valid"), 256'(digest_valid[i]), 256'(outq[i]));
            chk(nm(i, "digest"),       digest[i],             outq[i] ? mh[i] : '0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic send(input int i, input logic [511:0] data, input logic last, input int dly,
                        input bit noisy, input bit chk_lit, input logic [255:0] lit, input int lit_cyc);
        int           n;
        logic         fin;
        logic [255:0] held;
        n = 0;
        while (!blk_ready[i] && n < 600) begin
            tick();
            n++;
        end
        chk(nm(i, "idle_wait"), 256'(blk_ready[i]), 256'(1));
`ifdef SHA256_MULTI_BLOCK_EN
        fin = last;
`else
        fin = 1'b1;
`endif
        blk_valid[i] = 1'b1;
        blk_data[i]  = data;
        blk_last[i]  = last;
        tick();
        n = 1;
        if (noisy) blk_data[i] = rand512();
        else blk_valid[i] = 1'b0;
        while (!digest_valid[i] && !(n > 1 && blk_ready[i]) && n < 400) begin
            tick();
            n++;
            if (n >= 20) blk_valid[i] = 1'b0;
        end
        blk_valid[i] = 1'b0;
        if (fin) begin
            chk(nm(i, "valid_wait"), 256'(digest_valid[i]), 256'(1));
            if (lit_cyc > 0) chk(nm(i, "valid_cycle"), 256'(n), 256'(lit_cyc));
            if (chk_lit) chk(nm(i, "digest_lit"), digest[i], lit);
            held = digest[i];
            repeat (dly) tick();
            chk(nm(i, "digest_hold"), digest[i], held);
            chk(nm(i, "ready_in_out"), 256'(blk_ready[i]), 256'(0));
            digest_ready[i] = 1'b1;
            tick();
            digest_ready[i] = 1'b0;
            chk(nm(i, "idle_after_ack"), 256'(blk_ready[i]), 256'(1));
            chk(nm(i, "valid_after_ack"), 256'(digest_valid[i]), 256'(0));
        end else begin
            chk(nm(i, "no_digest"), 256'(digest_valid[i]), 256'(0));
            chk(nm(i, "chain_idle"), 256'(blk_ready[i]), 256'(1));
            chk(nm(i, "chain_cycle"), 256'(n), 256'(3 + 64 * lat_of(i)));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            blk_valid[i]    = 1'b0;
            blk_data[i]     = '0;
            blk_last[i]     = 1'b0;
            digest_ready[i] = 1'b0;
        end

        // Pin the model to published digests before trusting it.
        chk("model_abc",   compress(IV_M, BLK_ABC),   DIG_ABC);
        chk("model_empty", compress(IV_M, BLK_EMPTY), DIG_EMPTY);
        chk("model_two",   compress(compress(IV_M, BLK_TWO_A), BLK_TWO_B), DIG_TWO);

        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        send(0, BLK_ABC,   1'b1, 0,  1'b0, 1'b1, DIG_ABC,   67);
        send(0, BLK_EMPTY, 1'b1, 10, 1'b0, 1'b1, DIG_EMPTY, 67);
`ifdef SHA256_MULTI_BLOCK_EN
        send(0, BLK_TWO_A, 1'b0, 0, 1'b0, 1'b0, '0, 0);
        send(0, BLK_TWO_B, 1'b1, 2, 1'b0, 1'b1, DIG_TWO, 67);
`else
        send(0, BLK_TWO_A, 1'b0, 0, 1'b0, 1'b0, '0, 67);
        send(0, BLK_TWO_B, 1'b1, 2, 1'b0, 1'b0, '0, 67);
`endif
        send(1, BLK_ABC,   1'b1, 1, 1'b0, 1'b1, DIG_ABC,   195);
        send(1, BLK_EMPTY, 1'b1, 0, 1'b1, 1'b1, DIG_EMPTY, 195);

        // Abort a block mid-rounds, then confirm a clean restart.
        blk_valid[0] = 1'b1;
        blk_data[0]  = BLK_ABC;
        blk_last[0]  = 1'b1;
        tick();
        blk_valid[0] = 1'b0;
        repeat (29) tick();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk(nm(i, "rst_ready"),  256'(blk_ready[i]),    256'(0));
            chk(nm(i, "rst_load"),   256'(core_load[i]),    256'(0));
            chk(nm(i, "rst_init"),   core_init[i],          256'(0));
            chk(nm(i, "rst_en"),     256'(core_en[i]),      256'(0));
            chk(nm(i, "rst_w"),      256'(core_w[i]),       256'(0));
            chk(nm(i, "rst_k"),      256'(core_k[i]),       256'(0));
            chk(nm(i, "rst_valid"),  256'(digest_valid[i]), 256'(0));
            chk(nm(i, "rst_digest"), digest[i],             256'(0));
        end
        tick();
        tick();
        rst_n = 1'b1;
        send(0, BLK_ABC, 1'b1, 0, 1'b0, 1'b1, DIG_ABC, 67);

        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 5; r++) begin
                send(i, rand512(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                     1'($urandom_range(0, 1)), 1'b0, '0, 0);
            end
            send(i, rand512(), 1'b1, int'($urandom_range(0, 4)), 1'b0, 1'b0, '0, 3 + 64 * lat_of(i));
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
